// File: rtl/sprite_attr_mem_pkg.sv
// Shared definitions for the sprite attribute memory: FSM states, the
// byte layout of a 4-byte sprite entry and the default clear byte.
package sprite_attr_mem_pkg;

    // Controller states: CLEAR sweeps every word with the clear byte, RUN serves ports.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Byte positions of the sprite fields inside one 32-bit entry.
    localparam int FIELD_Y    = 0;
    localparam int FIELD_TILE = 1;
    localparam int FIELD_ATTR = 2;
    localparam int FIELD_X    = 3;

    // A Y coordinate of FF places the sprite off-screen, so clearing to FF hides it.
    localparam logic [7:0] DEFAULT_CLEAR_VALUE = 8'hFF;

    // Pick byte lane idx (0 = bits 7:0) out of a 32-bit word.
    function automatic logic [7:0] getByte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sprite_attr_ram.sv
// Single-clock sprite attribute storage: DEPTH x 32 bits with per-byte write
// enables and a registered 32-bit read. A read in the same cycle as a write
// to the same word returns the old contents; the parent handles forwarding.
module sprite_attr_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic [3:0]    wrEn_i,
    input  logic [AW-1:0] wrAddr_i,
    input  logic [31:0]   wrData_i,
    input  logic          rdEn_i,
    input  logic [AW-1:0] rdAddr_i,
    output logic [31:0]   rdData_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdData_q;

    // Byte-granular write: only lanes with their enable set are updated.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (wrEn_i[b]) begin
                mem_q[wrAddr_i][8*b +: 8] <= wrData_i[8*b +: 8];
            end
        end
    end

    // Registered read; the output holds between reads.
    always_ff @(posedge clk_i) begin
        if (rdEn_i) begin
            rdData_q <= mem_q[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/sprite_attr_mem.sv
// Sprite attribute memory (OAM). After reset a CLEAR sweep writes CLEAR_VALUE
// into every byte, one word per cycle, then the block serves a 32-bit
// byte-enabled write port and an 8-bit read port with one cycle latency.
// Optional feature macro: OAM_READ_BYPASS_EN -- when defined, a read that
// coincides with a write is accepted and forwards the written byte on a hit;
// when undefined, any write cycle stalls a concurrent read.
module sprite_attr_mem
    import sprite_attr_mem_pkg::*;
#(
    parameter int         NUM_SPRITES = 64,
    parameter logic [7:0] CLEAR_VALUE = DEFAULT_CLEAR_VALUE,
    localparam int        WA          = $clog2(NUM_SPRITES),
    localparam int        BA          = WA + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [WA-1:0] w_addr,
    input  logic [3:0]    w_enable,
    input  logic [31:0]   data_in,
    input  logic [BA-1:0] r_addr,
    input  logic          r_enable,
    output logic [7:0]    data_out,
    output logic          r_valid,
    output logic          r_stall,
    output logic          busy
);

    localparam logic [WA-1:0] LAST_PTR = WA'(NUM_SPRITES - 1);

    state_t        state_q;
    logic [WA-1:0] clrPtr_q;
    logic          busy_q;
    logic          rValid_q;

    logic [1:0]    byteSel_q;
    logic          bypassHit_q;
    logic [7:0]    bypassByte_q;
    logic [7:0]    dataHold_q;
    logic [7:0]    dataHold_d;

    logic          inRun;
    logic          writeReq;
    logic [WA-1:0] readWord;
    logic [1:0]    readByte;
    logic          collisionOk;
    logic          bypassHit;
    logic          readAccept;
    logic [7:0]    readResult;

    logic [3:0]    ramWe;
    logic [WA-1:0] ramWAddr;
    logic [31:0]   ramWData;
    logic [31:0]   ramRData;

    assign inRun    = (state_q == ST_RUN);
    assign writeReq = |w_enable;
    assign readWord = r_addr[BA-1:2];
    assign readByte = r_addr[1:0];

`ifdef OAM_READ_BYPASS_EN
    // A colliding read is still accepted; forward the new byte if it is being written now.
    assign collisionOk = 1'b1;
    assign bypassHit   = writeReq && (readWord == w_addr) && w_enable[readByte];
`else
    // Without forwarding, a read can only go when the write port is idle.
    assign collisionOk = ~writeReq;
    assign bypassHit   = 1'b0;
`endif

    assign readAccept = inRun & r_enable & collisionOk;
    assign r_stall    = r_enable & ~readAccept;

    // RAM write port source: the clear sweep owns it in CLEAR, the user port in RUN.
    always_comb begin
        ramWe    = 4'b0000;
        ramWAddr = w_addr;
        ramWData = data_in;
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                ramWe    = 4'b1111;
                ramWAddr = clrPtr_q;
                ramWData = {4{CLEAR_VALUE}};
            end else begin
                ramWe    = w_enable;
            end
        end
    end

    sprite_attr_ram #(
        .DEPTH (NUM_SPRITES),
        .AW    (WA)
    ) u_ram (
        .clk_i    (clk),
        .wrEn_i   (ramWe),
        .wrAddr_i (ramWAddr),
        .wrData_i (ramWData),
        .rdEn_i   (readAccept),
        .rdAddr_i (readWord),
        .rdData_o (ramRData)
    );

    // Controller: clear sweep pointer, state, busy and the read-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_CLEAR;
            clrPtr_q <= '0;
            busy_q   <= 1'b1;
            rValid_q <= 1'b0;
        end else begin
            rValid_q <= readAccept;
            case (state_q)
                ST_CLEAR: begin
                    if (clrPtr_q == LAST_PTR) begin
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b0;
                        clrPtr_q <= '0;
                    end else begin
                        clrPtr_q <= clrPtr_q + WA'(1);
                    end
                end
                ST_RUN: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_CLEAR;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Remember which byte was asked for and any forwarded byte for the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            byteSel_q    <= 2'b00;
            bypassHit_q  <= 1'b0;
            bypassByte_q <= 8'h00;
        end else if (readAccept) begin
            byteSel_q    <= readByte;
            bypassHit_q  <= bypassHit;
            bypassByte_q <= getByte(data_in, readByte);
        end
    end

    assign readResult = bypassHit_q ? bypassByte_q : getByte(ramRData, byteSel_q);

    // Hold register keeps data_out stable while no read result is being presented.
    always_comb begin
        dataHold_d = dataHold_q;
        if (rValid_q) begin
            dataHold_d = readResult;
        end
    end

    // Capture the presented read byte so it survives idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataHold_q <= 8'h00;
        end else begin
            dataHold_q <= dataHold_d;
        end
    end

    assign data_out = rValid_q ? readResult : dataHold_q;
    assign r_valid  = rValid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sprite_attr_mem.sv
// Self-checking bench for sprite_attr_mem: directed read/write vectors from a
// table plus hand-written sequences for clear timing, collisions, streaming
// reads and reset during clear / during a read.
module tb_sprite_attr_mem;
    import sprite_attr_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [5:0]  w_addr;
    logic [3:0]  w_enable;
    logic [31:0] data_in;
    logic [7:0]  r_addr;
    logic        r_enable;
    logic [7:0]  data_out;
    logic        r_valid;
    logic        r_stall;
    logic        busy;

    logic [7:0]  dataOut8, dataOut256;
    logic        rValid8, rStall8, busy8;
    logic        rValid256, rStall256, busy256;

    int checkCount = 0;
    int passCount  = 0;

    sprite_attr_mem #(.NUM_SPRITES(64)) dut (
        .clk(clk), .rst(rst), .w_addr(w_addr), .w_enable(w_enable), .data_in(data_in),
        .r_addr(r_addr), .r_enable(r_enable), .data_out(data_out), .r_valid(r_valid),
        .r_stall(r_stall), .busy(busy)
    );

    sprite_attr_mem #(.NUM_SPRITES(8)) dut8 (
        .clk(clk), .rst(rst), .w_addr(3'd0), .w_enable(4'd0), .data_in(32'd0),
        .r_addr(5'd0), .r_enable(1'b0), .data_out(dataOut8), .r_valid(rValid8),
        .r_stall(rStall8), .busy(busy8)
    );

    sprite_attr_mem #(.NUM_SPRITES(256)) dut256 (
        .clk(clk), .rst(rst), .w_addr(8'd0), .w_enable(4'd0), .data_in(32'd0),
        .r_addr(10'd0), .r_enable(1'b0), .data_out(dataOut256), .r_valid(rValid256),
        .r_stall(rStall256), .busy(busy256)
    );

    typedef struct {
        logic        doWr;
        logic [5:0]  wAddr;
        logic [3:0]  wEn;
        logic [31:0] wData;
        logic [7:0]  rAddr;
        logic [7:0]  expData;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(input logic doWr, input logic [5:0] wAddr, input logic [3:0] wEn,
                                   input logic [31:0] wData, input logic [7:0] rAddr, input logic [7:0] expData);
        vec_t v;
        v.doWr = doWr; v.wAddr = wAddr; v.wEn = wEn; v.wData = wData;
        v.rAddr = rAddr; v.expData = expData;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input logic [5:0] a, input logic [3:0] en, input logic [31:0] d);
        w_addr = a; w_enable = en; data_in = d;
        step();
        w_enable = 4'b0000;
    endtask

    task automatic doRead(input logic [7:0] a, input logic [7:0] exp, input string name);
        r_addr = a; r_enable = 1'b1;
        #1;
        checkOutput({name, " stall"}, 32'(r_stall), 32'd0);
        step();
        r_enable = 1'b0;
        checkOutput({name, " valid"}, 32'(r_valid), 32'd1);
        checkOutput({name, " data"}, 32'(data_out), 32'(exp));
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        if (v.doWr) doWrite(v.wAddr, v.wEn, v.wData);
        doRead(v.rAddr, v.expData, $sformatf("vec%0d addr%0d", idx, v.rAddr));
    endtask

    initial begin
        int cnt64, cnt8, cnt256, cnt;

        vecs.push_back(mkVec(1'b0, 6'd0,  4'b0000, 32'h0,        8'd0,   8'hFF));
        vecs.push_back(mkVec(1'b0, 6'd0,  4'b0000, 32'h0,        8'd127, 8'hFF));
        vecs.push_back(mkVec(1'b0, 6'd0,  4'b0000, 32'h0,        8'd255, 8'hFF));
        vecs.push_back(mkVec(1'b1, 6'd5,  4'b0101, 32'hAABBCCDD, 8'd20,  8'hDD));
        vecs.push_back(mkVec(1'b0, 6'd0,  4'b0000, 32'h0,        8'd21,  8'hFF));
        vecs.push_back(mkVec(1'b0, 6'd0,  4'b0000, 32'h0,        8'd22,  8'hBB));
        vecs.push_back(mkVec(1'b0, 6'd0,  4'b0000, 32'h0,        8'd23,  8'hFF));
        vecs.push_back(mkVec(1'b1, 6'd9,  4'(1 << FIELD_TILE), 32'h12345678, 8'(9*4 + FIELD_TILE), 8'h56));
        vecs.push_back(mkVec(1'b0, 6'd0,  4'b0000, 32'h0,        8'(9*4 + FIELD_Y), 8'hFF));
        vecs.push_back(mkVec(1'b0, 6'd0,  4'b0000, 32'h0,        8'd252, 8'hFF));
        vecs.push_back(mkVec(1'b1, 6'd63, 4'b1000, 32'hDEADBEEF, 8'd255, 8'hDE));

        rst = 1'b1; w_addr = '0; w_enable = '0; data_in = '0; r_addr = '0; r_enable = 1'b0;
        step();
        checkOutput("reset busy", 32'(busy), 32'd1);
        checkOutput("reset r_valid", 32'(r_valid), 32'd0);
        checkOutput("reset data_out", 32'(data_out), 32'h00);
        checkOutput("reset busy8", 32'(busy8), 32'd1);
        checkOutput("reset busy256", 32'(busy256), 32'd1);
        rst = 1'b0;

        cnt64 = 0; cnt8 = 0; cnt256 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!busy && !busy8 && !busy256) break;
            cnt64 += int'(busy); cnt8 += int'(busy8); cnt256 += int'(busy256);
            step();
        end
        checkOutput("clear cycles 64", 32'(cnt64), 32'd64);
        checkOutput("clear cycles 8", 32'(cnt8), 32'd8);
        checkOutput("clear cycles 256", 32'(cnt256), 32'd256);

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        step();
        checkOutput("hold r_valid", 32'(r_valid), 32'd0);
        checkOutput("hold data_out", 32'(data_out), 32'hDE);

        doWrite(6'd7, 4'b1111, 32'h55667788);
        doRead(8'd28, 8'h88, "wr-then-rd lo");
        doRead(8'd31, 8'h55, "wr-then-rd hi");

        w_addr = 6'd3; w_enable = 4'b1111; data_in = 32'h11223344;
        r_addr = 8'd12; r_enable = 1'b1;
        #1;
`ifdef OAM_READ_BYPASS_EN
        checkOutput("collision stall", 32'(r_stall), 32'd0);
        step();
        w_enable = 4'b0000; r_enable = 1'b0;
        checkOutput("collision valid", 32'(r_valid), 32'd1);
        checkOutput("collision data", 32'(data_out), 32'h44);
`else
        checkOutput("collision stall", 32'(r_stall), 32'd1);
        step();
        w_enable = 4'b0000;
        checkOutput("collision no valid", 32'(r_valid), 32'd0);
        doRead(8'd12, 8'h44, "collision retry");
`endif

        doWrite(6'd0, 4'b1111, 32'h03020100);
        doWrite(6'd1, 4'b1111, 32'h07060504);
        r_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r_addr = 8'(i);
            step();
            checkOutput($sformatf("stream%0d valid", i), 32'(r_valid), 32'd1);
            checkOutput($sformatf("stream%0d data", i), 32'(data_out), 32'(i));
        end
        r_enable = 1'b0;

        r_addr = 8'd20; r_enable = 1'b1;
        step();
        r_enable = 1'b0; rst = 1'b1;
        checkOutput("pre-reset read data", 32'(data_out), 32'hDD);
        step();
        rst = 1'b0;
        checkOutput("mid-read reset r_valid", 32'(r_valid), 32'd0);
        checkOutput("mid-read reset data_out", 32'(data_out), 32'h00);
        checkOutput("mid-read reset busy", 32'(busy), 32'd1);

        repeat (30) step();
        checkOutput("busy at clear cycle 30", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;

        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (!busy) break;
            cnt++;
            if (cnt == 40) begin
                w_addr = 6'd2; w_enable = 4'b1111; data_in = 32'h00000000;
                r_addr = 8'd8; r_enable = 1'b1;
                #1;
                checkOutput("stall during clear", 32'(r_stall), 32'd1);
            end
            step();
            w_enable = 4'b0000; r_enable = 1'b0;
            if (cnt == 40) checkOutput("no read during clear", 32'(r_valid), 32'd0);
        end
        checkOutput("restarted clear cycles", 32'(cnt), 32'd64);

        doRead(8'd8, 8'hFF, "dropped write b0");
        doRead(8'd10, 8'hFF, "dropped write b2");
        doRead(8'd20, 8'hFF, "recleared word5");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
